// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending stores that drains to a single-request memory bus.
// Stores are formatted (lane-replicated data, byte enables) on push and presented
// head-first while mem_req is high; loads stall until the buffer has drained.
// Optional feature: define STORE_MISALIGN_TRAP_EN to reject misaligned SH/SW
// stores with a one-cycle misalign pulse instead of buffering them.
module store_buffer #(
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [5:0]  cuOP,
   input  logic        op_valid,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        buf_empty,
   output logic        misalign
);

   localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [5:0] CuLb  = 6'd10;
   localparam logic [5:0] CuLhu = 6'd14;
   localparam logic [5:0] CuSb  = 6'd15;
   localparam logic [5:0] CuSh  = 6'd16;
   localparam logic [5:0] CuSw  = 6'd17;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StReq  = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   // Entry layout: {word address, write data, byte enables}
   logic [67:0]     buf_q [BUF_DEPTH];

   logic        is_store, is_load, reject, full, push, pop;
   logic [31:0] fmt_wdata;
   logic [3:0]  fmt_be;
   logic [67:0] head;

   assign is_store = op_valid && (cuOP == CuSb || cuOP == CuSh || cuOP == CuSw);
   assign is_load  = op_valid && (cuOP >= CuLb) && (cuOP <= CuLhu);
   assign full     = (count_q == CntW'(BUF_DEPTH));
   assign buf_empty = (count_q == '0);

`ifdef STORE_MISALIGN_TRAP_EN
   logic misalign_q;

   assign reject = is_store &&
                   (((cuOP == CuSh) && addr[0]) || ((cuOP == CuSw) && (addr[1:0] != 2'b00)));

   // Misalign pulse appears the cycle after the rejected store was presented
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) misalign_q <= 1'b0;
      else       misalign_q <= reject;
   end

   assign misalign = misalign_q;
`else
   assign reject   = 1'b0;
   assign misalign = 1'b0;
`endif

   // A full buffer blocks the store even when the head is popping this cycle
   assign push  = is_store && !reject && !full;
   assign pop   = (state_q == StReq) && mem_ack;
   assign stall = (is_store && !reject && full) || (is_load && !buf_empty);

   // Lane replication and byte enables for the incoming store
   always_comb begin
      fmt_wdata = storeData;
      fmt_be    = 4'b1111;
      case (cuOP)
         CuSb: begin
            fmt_wdata = {4{storeData[7:0]}};
            fmt_be    = 4'b0001 << addr[1:0];
         end
         CuSh: begin
            fmt_wdata = {2{storeData[15:0]}};
            fmt_be    = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Pointer, count and request-state next values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CntW'(push) - CntW'(pop);
      state_d  = state_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case (state_q)
         // Uses the settled count so a fresh push reaches the bus one edge later
         StIdle: if (count_q != '0) state_d = StReq;
         StReq:  if (mem_ack) state_d = (count_d != '0) ? StReq : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= StIdle;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are only observed while valid, so no reset needed
   always_ff @(posedge clk) begin
      if (push) buf_q[wr_ptr_q] <= {addr[31:2], 2'b00, fmt_wdata, fmt_be};
   end

   assign head      = buf_q[rd_ptr_q];
   assign mem_req   = (state_q == StReq);
   assign mem_addr  = mem_req ? head[67:36] : 32'h0;
   assign mem_wdata = mem_req ? head[35:4]  : 32'h0;
   assign mem_be    = mem_req ? head[3:0]   : 4'h0;

endmodule
